// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sel
// Purpose  : N-channel, DW-bit registered multiplexer with two selection
//            modes and a valid/ready output handshake.
//              * manual mode : the sample comes from the channel on s
//              * scan mode   : a round-robin pointer over the channels enabled
//                              in ch_mask picks the sample, staying on each
//                              channel for DWELL accepted samples
//            Every sample is tagged with the index of its source channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   1          system clock, rising edge
//   rst_n    in   1          synchronous active-low reset
//   i        in   N_CH*DW    packed channel inputs, channel k = i[k*DW +: DW]
//   s        in   SEL_W      manual channel select
//   mode     in   1          0 = manual, 1 = auto-scan
//   en       in   1          capture enable
//   ch_mask  in   N_CH       scan-mode channel enable (bit k includes chan k)
//   y        out  DW         registered selected sample
//   y_ch     out  SEL_W      channel index of the sample on y
//   y_valid  out  1          y / y_ch hold a sample not yet accepted
//   y_ready  in   1          downstream accepts when y_valid && y_ready
//   err      out  1          one-cycle pulse: manual s >= N_CH, or scan with
//                            an all-zero ch_mask
// ============================================================================
module mux_scan_sel #(
    parameter  int N_CH  = 8,
    parameter  int DW    = 1,
    parameter  int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*DW-1:0]   i,
    input  logic [SEL_W-1:0]     s,
    input  logic                 mode,
    input  logic                 en,
    input  logic [N_CH-1:0]      ch_mask,
    output logic [DW-1:0]        y,
    output logic [SEL_W-1:0]     y_ch,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 err
);

    // Dwell counter only has to reach DWELL-1.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // One extra bit so the range check of s is meaningful even when N_CH is
    // a power of two.
    localparam logic [SEL_W:0]   c_n_ch       = (SEL_W+1)'(N_CH);
    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [DW-1:0]    r_y;
    logic [SEL_W-1:0] r_y_ch;
    logic             r_y_valid;
    logic             r_err;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode_d;        // mode delayed one clock, for edge detect
    logic             r_restart_pend;  // scan entry seen, not yet consumed by a capture

    // ------------------------------------------------------------------------
    // Channel search helpers
    // ------------------------------------------------------------------------
    // Next enabled channel strictly above p, wrapping modulo N_CH. If p is the
    // only enabled channel the search wraps all the way back to p itself.
    function automatic logic [SEL_W-1:0] f_next_en(
        input logic [SEL_W-1:0] p,
        input logic [N_CH-1:0]  m
    );
        logic [SEL_W-1:0] r;
        logic             found;
        int               idx;
        r     = p;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(p) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && m[idx]) begin
                r     = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Lowest enabled channel (0 when none is enabled; caller guards that case).
    function automatic logic [SEL_W-1:0] f_first_en(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (m[k]) begin
                r = SEL_W'(k);
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Channel unpacking and selection
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_ch [N_CH];

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_unpack
            assign w_ch[g] = i[g*DW +: DW];
        end
    endgenerate

    logic             w_cap;
    logic             w_restart;
    logic             w_mask_any;
    logic             w_s_ok;
    logic             w_ptr_en;
    logic             w_jump;
    logic [SEL_W-1:0] w_base;
    logic [SEL_W-1:0] w_sel;
    logic [CNT_W-1:0] w_cnt_eff;
    logic             w_dwell_end;
    logic [DW-1:0]    w_data;

    // A new sample is loaded whenever the output slot is free or being
    // emptied in this same edge.
    assign w_cap      = en && (!r_y_valid || y_ready);

    // Scan entry: the rising edge of mode is folded in combinationally so a
    // capture in the very cycle mode rises already starts from the lowest
    // enabled channel; otherwise the pending flag carries it to the next cap.
    assign w_restart  = r_restart_pend || (mode && !r_mode_d);

    assign w_mask_any = |ch_mask;
    assign w_s_ok     = ({1'b0, s} < c_n_ch);
    assign w_ptr_en   = ch_mask[r_ptr];

    // Channel to sample in scan mode. Leaving the current pointer (restart or
    // its mask bit got cleared) starts a fresh dwell on the new channel.
    assign w_jump     = w_restart || !w_ptr_en;
    assign w_base     = w_restart ? f_first_en(ch_mask)
                      : (w_ptr_en ? r_ptr : f_next_en(r_ptr, ch_mask));
    assign w_cnt_eff  = w_jump ? '0 : r_cnt;
    assign w_dwell_end = (w_cnt_eff == c_dwell_last);

    assign w_sel      = mode ? w_base : s;

    always_comb begin
        w_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_data = w_ch[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output, pointer and dwell registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y            <= '0;
            r_y_ch         <= '0;
            r_y_valid      <= 1'b0;
            r_err          <= 1'b0;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_mode_d       <= 1'b0;
            r_restart_pend <= 1'b0;
        end else begin
            r_mode_d       <= mode;
            r_err          <= 1'b0;
            r_restart_pend <= w_restart;

            if (w_cap) begin
                if (!mode) begin
                    if (w_s_ok) begin
                        r_y       <= w_data;
                        r_y_ch    <= s;
                        r_y_valid <= 1'b1;
                    end else begin
                        // Invalid select: drop the slot, keep the old data.
                        r_y_valid <= 1'b0;
                        r_err     <= 1'b1;
                    end
                end else if (w_mask_any) begin
                    r_y            <= w_data;
                    r_y_ch         <= w_base;
                    r_y_valid      <= 1'b1;
                    r_restart_pend <= 1'b0;
                    if (w_dwell_end) begin
                        r_ptr <= f_next_en(w_base, ch_mask);
                        r_cnt <= '0;
                    end else begin
                        r_ptr <= w_base;
                        r_cnt <= w_cnt_eff + CNT_W'(1);
                    end
                end else begin
                    // Nothing to scan: pointer and dwell hold.
                    r_y_valid <= 1'b0;
                    r_err     <= 1'b1;
                end
            end else if (r_y_valid && y_ready) begin
                // Accepted with no replacement: data stays, slot empties.
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised N-channel, W-bit registered multiplexer. It succeeds the team's fixed 8:1 combinational mux. Two modes are supported: manual select, where the sample comes from the channel on s, and auto-scan, where a round-robin pointer over masked channels picks the sample with a configurable dwell count. The output uses a valid/ready handshake, and each sample is tagged with its source channel. The block sits between the lab's input banks and downstream sample consumers such as a display/UART formatter.

Parameters:
N_CH, 8, number of input channels (2..64, need not be a power of two)
DW, 1, data width per channel in bits
DWELL, 1, number of accepted samples taken from one channel before scan advances (1..255)
SEL_W, $clog2(N_CH), width of the select and channel tag (localparam, derived)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
i  in  N_CH*DW  packed channel inputs; channel k = i[k*DW +: DW]
s  in  SEL_W  manual channel select
mode  in  1  0 = manual, 1 = auto-scan
en  in  1  capture enable
ch_mask  in  N_CH  scan-mode channel enable; bit k=1 includes channel k
y  out  DW  registered selected sample
y_ch  out  SEL_W  channel index of the sample on y
y_valid  out  1  y/y_ch hold a sample not yet accepted
y_ready  in  1  downstream accepts the sample when y_valid && y_ready
err  out  1  one-cycle pulse: manual s >= N_CH, or scan with ch_mask all zero

Behaviour:
- Reset (rst_n=0 at a clk edge) sets y=0, y_ch=0, y_valid=0, err=0, scan pointer=0 and dwell counter=0. Reset has priority over all other inputs, including mid-handshake; a pending sample is discarded.
- Capture condition: cap = en && (!y_valid || y_ready). Output registers load only on cap, so latency is 1 clk from the sampled inputs to y.
- Backpressure: while y_valid && !y_ready, y, y_ch and y_valid hold stable, and the scan pointer and dwell counter freeze.
- If en=0 and the sample is accepted (y_valid && y_ready), y_valid goes to 0 while y and y_ch hold their last values.
- Manual mode (mode=0), on cap:
  - If s < N_CH: y <= channel s, y_ch <= s, y_valid <= 1.
  - If s >= N_CH: y_valid <= 0, y and y_ch unchanged, err pulses for 1 cycle. The block never drives z.
- Scan mode (mode=1), on cap with ch_mask != 0:
  - y <= channel ptr, y_ch <= ptr, y_valid <= 1, dwell counter increments.
  - When the dwell counter reaches DWELL-1 it clears, and ptr moves to the next index above ptr with ch_mask=1, wrapping modulo N_CH.
  - If ptr's own mask bit is 0 at capture time, ptr first moves to the next enabled channel; that channel is sampled in the same cycle and the dwell counter restarts.
- Scan mode with ch_mask == 0 on cap: y_valid <= 0, err pulses, ptr holds.
- Mode entry: a 0->1 transition of mode, registered internally, resets ptr to the lowest enabled channel and clears the dwell counter. That transition takes effect from the next cap. Transition 1->0 leaves ptr untouched.
- Simultaneous accept and capture: when y_valid && y_ready && en, the new sample replaces the old in the same edge and y_valid stays 1, giving back-to-back throughput of 1 sample/clk.
- Changes to ch_mask mid-dwell take effect at the next pointer advance or validity check.
- err is a registered pulse and is otherwise 0.

Test Plan:
1. Reset: hold rst_n=0 for 3 clks with en=1 and i=all ones -> y=0, y_ch=0, y_valid=0, err=0 throughout.
2. Manual sweep (N_CH=8, DW=1, i=8'b1010_0110, y_ready=1): s=0..7 on consecutive clks -> y follows i[s] 1 clk later (0,1,1,0,0,1,0,1), y_ch=s, y_valid=1 continuously.
3. Out-of-range (N_CH=6): s=7 with en=1 -> y_valid=0 the next clk, err=1 for exactly 1 clk, y/y_ch unchanged.
4. Scan with mask and dwell (N_CH=8, DWELL=2, ch_mask=8'b1000_0101, y_ready=1): y_ch sequence is 0,0,2,2,7,7,0,0…, wrapping from 7 to 0.
5. Backpressure: in scan, drop y_ready for 4 clks -> y, y_ch and y_valid frozen. On re-assert, the next sample comes from the channel that continues the sequence, with no channel skipped or repeated beyond DWELL.
6. Edge cases:
   - ch_mask=0 in scan -> y_valid=0 and an err pulse.
   - Toggle mode 0->1 with ch_mask=8'b0001_0000 -> the first scan sample has y_ch=4.
   - Assert rst_n=0 while y_valid=1 && y_ready=0 -> y_valid=0 on the next edge.
